// File: rtl/tone_clock_divider_if.sv
// rtl/tone_clock_divider_if.sv - control and tone/tick bundle between selector, divider and shapers
`timescale 1ns/1ps
interface tone_clock_divider_if #(
  parameter int CNT_W = 32
);
  logic             ena;
  logic [CNT_W-1:0] clk_div_threshold;
  logic             tone_out;
  logic             half_tick;
  logic             period_tick;
  logic             running;
  logic             update_pending;

  modport master (
    output ena, clk_div_threshold,
    input  tone_out, half_tick, period_tick, running, update_pending
  );

  modport slave (
    input  ena, clk_div_threshold,
    output tone_out, half_tick, period_tick, running, update_pending
  );
endinterface

// File: rtl/tone_clock_divider.sv
// rtl/tone_clock_divider.sv - half-period tone divider with boundary-only threshold updates
`timescale 1ns/1ps
module tone_clock_divider #(
  parameter int CNT_W   = 32,
  parameter int MIN_THR = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tone_clock_divider_if.slave  bus
);

  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_THR);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [CNT_W-1:0] r_thr_s, w_thr_n;
  logic             r_tone, w_tone_n;
  logic             r_half_tick, w_half_n;
  logic             r_period_tick, w_period_n;
  logic             r_running, w_running_n;
  logic             r_update_pending, w_pending_n;

  logic [CNT_W-1:0] w_thr_in;
  logic [CNT_W-1:0] w_thr_last;

  assign w_thr_in   = (bus.clk_div_threshold < MIN_V) ? MIN_V : bus.clk_div_threshold;
  assign w_thr_last = r_thr_s - CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_thr_s          <= MIN_V;
      r_tone           <= 1'b0;
      r_half_tick      <= 1'b0;
      r_period_tick    <= 1'b0;
      r_running        <= 1'b0;
      r_update_pending <= 1'b0;
    end else begin
      r_state          <= w_state_n;
      r_cnt            <= w_cnt_n;
      r_thr_s          <= w_thr_n;
      r_tone           <= w_tone_n;
      r_half_tick      <= w_half_n;
      r_period_tick    <= w_period_n;
      r_running        <= w_running_n;
      r_update_pending <= w_pending_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_thr_n    = r_thr_s;
    w_tone_n   = r_tone;
    w_half_n   = 1'b0;
    w_period_n = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_n  = '0;
        w_tone_n = 1'b0;
        w_thr_n  = w_thr_in;
        if (bus.ena) w_state_n = S_RUN;
      end
      S_RUN: begin
        // a disable beats a coincident boundary: no toggle, no tick
        if (!bus.ena) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          w_tone_n  = 1'b0;
        end else if (r_cnt == w_thr_last) begin
          w_cnt_n    = '0;
          w_tone_n   = ~r_tone;
          w_half_n   = 1'b1;
          w_period_n = r_tone;
          w_thr_n    = w_thr_in;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
        w_tone_n  = 1'b0;
      end
    endcase
    w_running_n = (w_state_n == S_RUN);
    // compared against the shadow value that will be active next cycle
    w_pending_n = w_running_n && (w_thr_in != w_thr_n);
  end

  assign bus.tone_out       = r_tone;
  assign bus.half_tick      = r_half_tick;
  assign bus.period_tick    = r_period_tick;
  assign bus.running        = r_running;
  assign bus.update_pending = r_update_pending;

endmodule
